synaptic_current: RTL and testbench

SYNAPTIC_CURRENT -- requirements
Module: synaptic_current

---
 rtl/synaptic_current_pkg.sv | 20 ++
 rtl/synaptic_current_if.sv | 22 ++
 rtl/synaptic_current_decay_tick.sv | 30 +++
 rtl/synaptic_current.sv | 88 ++++++++
 tb/tb_synaptic_current.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/synaptic_current_pkg.sv
// Shared constants and types for the synaptic current stage.
//   DATA_W            width of weight and current values
//   DEF_DECAY_SHIFT   default decay step shift (step = current >> shift)
//   DEF_DECAY_PERIOD  default cycles between decay steps
//   syn_state_e       IDLE / ACTIVE state of the current integrator
//   sat_add           unsigned add clamped at the all-ones value
package stdp_pkg;
  localparam int DATA_W           = 8;
  localparam int DEF_DECAY_SHIFT  = 2;
  localparam int DEF_DECAY_PERIOD = 4;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} syn_state_e;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/synaptic_current_if.sv
// Signal bundle between the spike/weight source and synaptic_current.
//   pre_spike     presynaptic spike level
//   weight        synaptic weight, sampled when weight_valid is high
//   weight_valid  weight load strobe
//   current       synaptic current toward the postsynaptic neuron
//   active        integrator holds a non-zero current
//   evt_count     accepted spike events, modulo 256
// master = source side (testbench / upstream), slave = synaptic_current.
interface synaptic_current_if;
  import stdp_pkg::*;
  logic              pre_spike;
  logic [DATA_W-1:0] weight;
  logic              weight_valid;
  logic [DATA_W-1:0] current;
  logic              active;
  logic [7:0]        evt_count;

  modport master (output pre_spike, weight, weight_valid,
                  input  current, active, evt_count);
  modport slave  (input  pre_spike, weight, weight_valid,
                  output current, active, evt_count);
endinterface

// File: rtl/synaptic_current_decay_tick.sv
// Decay prescaler: counts 0..PERIOD-1 while enabled and raises tick for
// the single cycle in which the count sits at PERIOD-1, then wraps.
// clr forces the count back to 0 and has priority over en.
//   clk, rst_n  clock, async active-low reset
//   en          count enable
//   clr         synchronous clear
//   tick        one-cycle decay strobe
module syn_decay_tick #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(PERIOD - 1);

  logic [7:0] cnt;

  // Not gated by clr: clr is derived from the next state, which itself
  // depends on tick.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= (cnt == LAST) ? '0 : cnt + 8'd1;
  end
endmodule

// File: rtl/synaptic_current.sv
// Synaptic current integrator. A rising edge on pre_spike is one event:
// it adds the stored weight (saturating at 255) to the current and bumps
// evt_count. Between events the current decays geometrically every
// DECAY_PERIOD cycles by current >> DECAY_SHIFT (at least 1 while > 0).
//   clk, rst_n  clock, async active-low reset
//   bus         synaptic_current_if.slave (spike/weight in, current out)
// Build option SYN_EXP_DECAY_EN: when defined, the exponential-decay
// integrator above is built; when undefined, current is a one-cycle pulse
// of the stored weight after each event and no prescaler exists.
module synaptic_current
  import stdp_pkg::*;
#(
  parameter int DECAY_SHIFT  = DEF_DECAY_SHIFT,
  parameter int DECAY_PERIOD = DEF_DECAY_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  synaptic_current_if.slave   bus
);
  if (DECAY_SHIFT < 1 || DECAY_SHIFT > 7 ||
      DECAY_PERIOD < 1 || DECAY_PERIOD > 255) begin : g_bad_cfg
    $error("synaptic_current: DECAY_SHIFT or DECAY_PERIOD out of range");
  end

  logic [DATA_W-1:0] w_q, cur_q, cur_d;
  logic              spike_d;
  logic [7:0]        evt_q;
  logic              evt;
  syn_state_e        state_q, state_d;

  assign evt = bus.pre_spike & ~spike_d;

`ifdef SYN_EXP_DECAY_EN
  logic              tick;
  logic [DATA_W-1:0] step, base;

  // Prescaler runs only while ACTIVE and restarts on every drop to IDLE.
  syn_decay_tick #(.PERIOD(DECAY_PERIOD)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ACTIVE),
    .clr   (state_d == IDLE),
    .tick  (tick)
  );

  // Decay first, then add: an event landing on a tick builds on the
  // decayed value. w_q is the registered weight, so a same-cycle load
  // only takes effect for later events.
  always_comb begin
    step = cur_q >> DECAY_SHIFT;
    if (step == '0 && cur_q != '0) step = {{(DATA_W-1){1'b0}}, 1'b1};
    base  = tick ? cur_q - step : cur_q;
    cur_d = evt ? sat_add(base, w_q) : base;
  end
`else
  assign cur_d = evt ? w_q : '0;
`endif

  // ACTIVE exactly when the registered current is non-zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cur_d != '0) state_d = ACTIVE;
      ACTIVE:  if (cur_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      w_q     <= '0;
      spike_d <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      spike_d <= bus.pre_spike;
      if (bus.weight_valid) w_q <= bus.weight;
      if (evt) evt_q <= evt_q + 8'd1;
    end
  end

  assign bus.current   = cur_q;
  assign bus.active    = (state_q == ACTIVE);
  assign bus.evt_count = evt_q;
endmodule

// File: tb/tb_synaptic_current.sv
// Self-checking bench for synaptic_current: a table of hand-derived
// vectors, hand-written corner sequences and randomized traffic compared
// against a cycle-level arithmetic model. Builds for either setting of
// SYN_EXP_DECAY_EN.
module tb_synaptic_current;
  localparam int DS = 2;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  synaptic_current_if sif();

  synaptic_current #(.DECAY_SHIFT(DS), .DECAY_PERIOD(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, one call per clock edge.
  int m_w, m_cur, m_cnt;
  bit m_prev;
`ifdef SYN_EXP_DECAY_EN
  int m_age;  // cycles spent with a non-zero current since it last became non-zero
`endif

  task automatic model_reset();
    m_w = 0; m_cur = 0; m_cnt = 0; m_prev = 0;
`ifdef SYN_EXP_DECAY_EN
    m_age = 0;
`endif
  endtask

  task automatic model_step(input bit pre, input bit wv, input int wt);
    bit ev;
    int nxt;
`ifdef SYN_EXP_DECAY_EN
    int base;
`endif
    ev = pre && !m_prev;
`ifdef SYN_EXP_DECAY_EN
    base = m_cur;
    if (m_cur > 0 && (m_age % DP) == DP - 1)
      base = m_cur - (((m_cur >> DS) > 0) ? (m_cur >> DS) : 1);
    nxt = ev ? ((base + m_w > 255) ? 255 : base + m_w) : base;
    m_age = (m_cur > 0 && nxt > 0) ? m_age + 1 : 0;
`else
    nxt = ev ? m_w : 0;
`endif
    if (ev) m_cnt = (m_cnt + 1) % 256;
    if (wv) m_w = wt;
    m_prev = pre;
    m_cur = nxt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, compare 1 time unit after the rising edge.
  task automatic step(input logic pre, input logic wv, input logic [7:0] wt);
    @(negedge clk);
    sif.pre_spike = pre; sif.weight_valid = wv; sif.weight = wt;
    @(posedge clk);
    model_step(pre, wv, int'(wt));
    #1;
    check("model_current", 32'(sif.current), 32'(m_cur));
    check("model_active", 32'(sif.active), 32'(m_cur != 0));
    check("model_evt_count", 32'(sif.evt_count), 32'(m_cnt));
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input logic pre_hold);
    @(negedge clk);
    sif.pre_spike = pre_hold; sif.weight_valid = 1'b0; sif.weight = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_current", 32'(sif.current), 0);
    check("rst_active", 32'(sif.active), 0);
    check("rst_evt_count", 32'(sif.evt_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       pre;
    logic       wv;
    logic [7:0] wt;
    logic [7:0] cur;
    logic       act;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];

  initial begin
    sif.pre_spike = 1'b0; sif.weight_valid = 1'b0; sif.weight = '0;
    model_reset();

    // ---- table-driven vectors ----
`ifdef SYN_EXP_DECAY_EN
    vt.push_back('{1'b0, 1'b1, 8'd64, 8'd0,  1'b0, 8'd0});
    vt.push_back('{1'b1, 1'b0, 8'd0,  8'd64, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd64, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd64, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd64, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd48, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd48, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd48, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd48, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd36, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd36, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd36, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd36, 1'b1, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd27, 1'b1, 8'd1});
`else
    vt.push_back('{1'b0, 1'b1, 8'd90, 8'd0,  1'b0, 8'd0});
    vt.push_back('{1'b1, 1'b0, 8'd0,  8'd90, 1'b1, 8'd1});
    vt.push_back('{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 8'd1});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 8'd1});
    vt.push_back('{1'b1, 1'b1, 8'd5,  8'd90, 1'b1, 8'd2});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 8'd2});
    vt.push_back('{1'b1, 1'b0, 8'd0,  8'd5,  1'b1, 8'd3});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 8'd3});
    vt.push_back('{1'b0, 1'b1, 8'd0,  8'd0,  1'b0, 8'd3});
    vt.push_back('{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 8'd4});
    vt.push_back('{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 8'd4});
`endif
    do_reset(1'b0);
    foreach (vt[i]) begin
      step(vt[i].pre, vt[i].wv, vt[i].wt);
      check($sformatf("vec%0d_current", i), 32'(sif.current), 32'(vt[i].cur));
      check($sformatf("vec%0d_active", i), 32'(sif.active), 32'(vt[i].act));
      check($sformatf("vec%0d_evt_count", i), 32'(sif.evt_count), 32'(vt[i].cnt));
    end

    // ---- two spikes two cycles apart, weight 200 ----
    do_reset(1'b0);
    step(1'b0, 1'b1, 8'd200);
    step(1'b1, 1'b0, 8'd0);
    check("w200_first", 32'(sif.current), 200);
    step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
`ifdef SYN_EXP_DECAY_EN
    check("w200_saturate", 32'(sif.current), 255);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("decay_from_255", 32'(sif.current), 192);
`else
    check("w200_second", 32'(sif.current), 200);
`endif
    check("w200_evt_count", 32'(sif.evt_count), 2);

`ifdef SYN_EXP_DECAY_EN
    // ---- small current decays by one per tick down to zero ----
    do_reset(1'b0);
    step(1'b0, 1'b1, 8'd3);
    step(1'b1, 1'b0, 8'd0);
    check("small_start", 32'(sif.current), 3);
    for (int k = 1; k <= 11; k++) step(1'b0, 1'b0, 8'd0);
    check("small_one", 32'(sif.current), 1);
    check("small_one_active", 32'(sif.active), 1);
    step(1'b0, 1'b0, 8'd0);
    check("small_zero", 32'(sif.current), 0);
    check("small_zero_active", 32'(sif.active), 0);
`endif

    // ---- held-high spike counts once ----
    do_reset(1'b0);
    step(1'b0, 1'b1, 8'd7);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 8'd0);
    check("held_evt_count", 32'(sif.evt_count), 1);

    // ---- 256 events wrap the counter ----
    do_reset(1'b0);
    step(1'b0, 1'b1, 8'd1);
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 8'd0);
    end
    check("wrap_evt_count", 32'(sif.evt_count), 0);

    // ---- reset mid-decay with spike held; edge history cleared ----
    do_reset(1'b0);
    step(1'b0, 1'b1, 8'd40);
    step(1'b1, 1'b0, 8'd0);
    check("pre_rst_current", 32'(sif.current), 40);
    step(1'b0, 1'b0, 8'd0);
    do_reset(1'b1);
    step(1'b1, 1'b0, 8'd0);
    check("post_rst_edge_count", 32'(sif.evt_count), 1);
    check("post_rst_zero_w", 32'(sif.current), 0);

    // ---- weight load coinciding with an event uses the old weight ----
    step(1'b0, 1'b1, 8'd50);
    step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd10);
    check("same_cycle_old_w", 32'(sif.current), 50);
    step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
`ifdef SYN_EXP_DECAY_EN
    check("next_event_new_w", 32'(sif.current), 60);
`else
    check("next_event_new_w", 32'(sif.current), 10);
`endif

    // ---- randomized traffic against the model ----
    do_reset(1'b0);
    for (int k = 0; k < 1500; k++) begin
      logic       p, wv;
      logic [7:0] wt;
      p  = ($urandom_range(0, 9) < 2);
      wv = ($urandom_range(0, 7) == 0);
      wt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      step(p, wv, wt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
